// File: rtl/mul_int8_accum.sv
// mul_int8_accum: groups a stream of unsigned products (delimited by in_last)
// into a wide running sum, then presents sum / term count / overflow on a
// registered valid/ready output. The block holds the result until it is
// taken and refuses new products meanwhile.
module mul_int8_accum #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ACC_WIDTH = 20,
  parameter int unsigned CNT_WIDTH = 8,
  parameter bit          SAT_EN    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_p,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_ovf
);

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   ovf_q, ovf_d;
  logic                   out_valid_q, out_valid_d;
  logic [ACC_WIDTH-1:0]   out_sum_q, out_sum_d;
  logic [CNT_WIDTH-1:0]   out_count_q, out_count_d;
  logic                   out_ovf_q, out_ovf_d;

  // Datapath for "accumulator after absorbing in_p".
  logic [ACC_WIDTH:0]     sum_ext;
  logic                   carry;
  logic [ACC_WIDTH-1:0]   acc_step;
  logic [CNT_WIDTH-1:0]   cnt_step;
  logic                   ovf_step;
  logic                   cnt_full;
  logic                   in_fire;
  logic                   out_fire;

  // Ready depends only on state so it can never loop back through in_valid.
  assign in_ready = (state_q == ST_ACC);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

  // One extra bit on the adder exposes the carry out of ACC_WIDTH.
  assign sum_ext = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - WIDTH){1'b0}}, in_p};
  assign carry   = sum_ext[ACC_WIDTH];

  // Saturating mode clamps at all-ones; once clamped, any further non-zero
  // term carries again, so the sum naturally stays pinned for the group.
  generate
    if (SAT_EN) begin : g_sat
      assign acc_step = carry ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    end else begin : g_wrap
      assign acc_step = sum_ext[ACC_WIDTH-1:0];
    end
  endgenerate

  // Term counter sticks at its maximum instead of wrapping; this is not an
  // overflow of the sum and so does not feed the ovf flag.
  assign cnt_full = (cnt_q == {CNT_WIDTH{1'b1}});
  assign cnt_step = cnt_full ? cnt_q : cnt_q + CNT_WIDTH'(1);
  assign ovf_step = ovf_q | carry;

  // Next-state and next-output logic; everything holds unless changed below.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      ST_ACC: begin
        if (in_fire) begin
          if (in_last) begin
            // Close the group: publish the result and start the next one clean.
            out_sum_d   = acc_step;
            out_count_d = cnt_step;
            out_ovf_d   = ovf_step;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = ST_HOLD;
          end else begin
            acc_d = acc_step;
            cnt_d = cnt_step;
            ovf_d = ovf_step;
          end
        end
      end
      ST_HOLD: begin
        // Result registers stay put; only the valid flag drops on hand-off.
        if (out_fire) begin
          out_valid_d = 1'b0;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State register; reset throws away any partial group or pending result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_mul_int8_accum.sv
// Bench for mul_int8_accum: four instances (default, 10-bit saturating,
// 10-bit wrapping, 2-bit counter) share one stimulus stream; each group's
// result is compared against hand-computed values per instance.
module tb_mul_int8_accum;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic [7:0] in_p = 8'd0;
  logic in_last = 1'b0;
  logic out_ready = 1'b0;

  always #5 clk = ~clk;

  // default instance
  logic        rdy0, val0, ovf0;
  logic [19:0] sum0;
  logic [7:0]  cnt0;
  // ACC_WIDTH=10 saturating
  logic        rdy1, val1, ovf1;
  logic [9:0]  sum1;
  logic [7:0]  cnt1;
  // ACC_WIDTH=10 wrapping
  logic        rdy2, val2, ovf2;
  logic [9:0]  sum2;
  logic [7:0]  cnt2;
  // CNT_WIDTH=2
  logic        rdy3, val3, ovf3;
  logic [19:0] sum3;
  logic [1:0]  cnt3;

  mul_int8_accum dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0), .in_p(in_p),
    .in_last(in_last), .out_valid(val0), .out_ready(out_ready), .out_sum(sum0),
    .out_count(cnt0), .out_ovf(ovf0));
  mul_int8_accum #(.ACC_WIDTH(10), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1), .in_p(in_p),
    .in_last(in_last), .out_valid(val1), .out_ready(out_ready), .out_sum(sum1),
    .out_count(cnt1), .out_ovf(ovf1));
  mul_int8_accum #(.ACC_WIDTH(10), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2), .in_p(in_p),
    .in_last(in_last), .out_valid(val2), .out_ready(out_ready), .out_sum(sum2),
    .out_count(cnt2), .out_ovf(ovf2));
  mul_int8_accum #(.CNT_WIDTH(2)) dut_cnt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3), .in_p(in_p),
    .in_last(in_last), .out_valid(val3), .out_ready(out_ready), .out_sum(sum3),
    .out_count(cnt3), .out_ovf(ovf3));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int          n;
    logic [7:0]  t[6];
    bit          gap;
    int          hold;
    logic [19:0] s0;   // default instance sum (also CNT_WIDTH=2 instance)
    logic [7:0]  c0;   // 8-bit counter value (default, sat, wrap)
    bit          o0;   // 20-bit overflow
    logic [9:0]  s_sat;
    bit          o_sat;
    logic [9:0]  s_wrap;
    bit          o_wrap;
    logic [1:0]  c_cnt;
  } grp_t;

  grp_t vec[6];

  // Drive one product and wait for its transfer edge; returns #1 after it.
  task automatic send_term(input logic [7:0] p, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_p     = p;
    in_last  = last;
    while (!rdy0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!rdy0) chk("in_ready_timeout", 32'(rdy0), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(val0), 32'd0);
    chk({tag, "_sum"},   32'(sum0), 32'd0);
    chk({tag, "_count"}, 32'(cnt0), 32'd0);
    chk({tag, "_ovf"},   32'(ovf0), 32'd0);
    chk({tag, "_sat_sum"}, 32'(sum1), 32'd0);
  endtask

  initial begin
    vec[0] = '{4, '{8'd3, 8'd5, 8'd7, 8'd9, 8'd0, 8'd0}, 1'b0, 0,
               20'd24, 8'd4, 1'b0, 10'd24, 1'b0, 10'd24, 1'b0, 2'd3};
    vec[1] = '{1, '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 5,
               20'd255, 8'd1, 1'b0, 10'd255, 1'b0, 10'd255, 1'b0, 2'd1};
    vec[2] = '{5, '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd0}, 1'b0, 0,
               20'd1275, 8'd5, 1'b0, 10'd1023, 1'b1, 10'd251, 1'b1, 2'd3};
    vec[3] = '{3, '{8'd10, 8'd20, 8'd30, 8'd0, 8'd0, 8'd0}, 1'b1, 0,
               20'd60, 8'd3, 1'b0, 10'd60, 1'b0, 10'd60, 1'b0, 2'd3};
    vec[4] = '{1, '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 1'b0, 0,
               20'd1, 8'd1, 1'b0, 10'd1, 1'b0, 10'd1, 1'b0, 2'd1};
    vec[5] = '{6, '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 1'b0, 0,
               20'd6, 8'd6, 1'b0, 10'd6, 1'b0, 10'd6, 1'b0, 2'd3};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(rdy0), 32'd1);
    check_reset_outputs("rst_post");

    // Table-driven groups
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < vec[g].n; i++) begin
        if (vec[g].gap && i > 0) begin
          // idle cycle with junk on the data lines
          in_valid = 1'b0;
          in_p     = 8'hAA;
          in_last  = 1'b1;
          @(posedge clk); #1;
          in_last  = 1'b0;
        end
        send_term(vec[g].t[i], (i == vec[g].n - 1));
      end
      $display("[TB] group %0d: sum=%0d count=%0d ovf=%0d sat_sum=%0d wrap_sum=%0d cnt2=%0d",
               g, sum0, cnt0, ovf0, sum1, sum2, cnt3);
      chk($sformatf("g%0d_valid", g), 32'(val0), 32'd1);
      chk($sformatf("g%0d_in_ready", g), 32'(rdy0), 32'd0);
      chk($sformatf("g%0d_sum", g), 32'(sum0), 32'(vec[g].s0));
      chk($sformatf("g%0d_count", g), 32'(cnt0), 32'(vec[g].c0));
      chk($sformatf("g%0d_ovf", g), 32'(ovf0), 32'(vec[g].o0));
      chk($sformatf("g%0d_sat_sum", g), 32'(sum1), 32'(vec[g].s_sat));
      chk($sformatf("g%0d_sat_ovf", g), 32'(ovf1), 32'(vec[g].o_sat));
      chk($sformatf("g%0d_sat_count", g), 32'(cnt1), 32'(vec[g].c0));
      chk($sformatf("g%0d_wrap_sum", g), 32'(sum2), 32'(vec[g].s_wrap));
      chk($sformatf("g%0d_wrap_ovf", g), 32'(ovf2), 32'(vec[g].o_wrap));
      chk($sformatf("g%0d_cnt2_count", g), 32'(cnt3), 32'(vec[g].c_cnt));
      chk($sformatf("g%0d_cnt2_sum", g), 32'(sum3), 32'(vec[g].s0));
      chk($sformatf("g%0d_cnt2_ovf", g), 32'(ovf3), 32'(vec[g].o0));

      // Back-pressure: result must stay put and new products be refused.
      for (int h = 0; h < vec[g].hold; h++) begin
        in_valid = 1'b1;
        in_p     = 8'h77;
        in_last  = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("g%0d_hold%0d_valid", g, h), 32'(val0), 32'd1);
        chk($sformatf("g%0d_hold%0d_in_ready", g, h), 32'(rdy0), 32'd0);
        chk($sformatf("g%0d_hold%0d_sum", g, h), 32'(sum0), 32'(vec[g].s0));
        chk($sformatf("g%0d_hold%0d_count", g, h), 32'(cnt0), 32'(vec[g].c0));
      end
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk($sformatf("g%0d_drop_valid", g), 32'(val0), 32'd0);
      chk($sformatf("g%0d_ready_back", g), 32'(rdy0), 32'd1);
      chk($sformatf("g%0d_sum_kept", g), 32'(sum0), 32'(vec[g].s0));
    end

    // Reset in the middle of a group
    send_term(8'd50, 1'b0);
    send_term(8'd60, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    #3;
    rst_n = 1'b1;
    send_term(8'd4, 1'b1);
    $display("[TB] post-reset group: sum=%0d count=%0d", sum0, cnt0);
    chk("mid_post_valid", 32'(val0), 32'd1);
    chk("mid_post_sum", 32'(sum0), 32'd4);
    chk("mid_post_count", 32'(cnt0), 32'd1);

    // Reset while holding a result
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_hold2");
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("hold_post_in_ready", 32'(rdy0), 32'd1);
    send_term(8'd4, 1'b1);
    $display("[TB] post-reset group: sum=%0d count=%0d", sum0, cnt0);
    chk("hold_post_sum", 32'(sum0), 32'd4);
    chk("hold_post_count", 32'(cnt0), 32'd1);
    chk("hold_post_ovf", 32'(ovf0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
